// File: rtl/nn_layer_sched_if.sv
// Handshake, config and status bundle for nn_layer_sched.
// The slave modport is the scheduler side; master is the source/sink side.
interface nn_layer_sched_if #(
   parameter int N_IN  = 2,
   parameter int N_OUT = 3,
   parameter int W_W   = 8
);
   localparam int N_CFG = N_OUT * (N_IN + 1);
   localparam int AW    = (N_CFG > 1) ? $clog2(N_CFG) : 1;

   logic                  cfg_we;
   logic [AW-1:0]         cfg_addr;
   logic signed [W_W-1:0] cfg_data;
   logic                  in_valid;
   logic                  in_ready;
   logic [N_IN-1:0]       in_x;
   logic                  out_valid;
   logic                  out_ready;
   logic [N_OUT-1:0]      out_y;
   logic                  busy;
   logic                  sat_flag;

   modport slave (
      input  cfg_we, cfg_addr, cfg_data, in_valid, in_x, out_ready,
      output in_ready, out_valid, out_y, busy, sat_flag
   );

   modport master (
      output cfg_we, cfg_addr, cfg_data, in_valid, in_x, out_ready,
      input  in_ready, out_valid, out_y, busy, sat_flag
   );
endinterface

// File: rtl/nn_layer_sched.sv
// Time-multiplexed binary-input neuron layer: one shared MAC + threshold datapath.
// Define NN_SAT_EN for saturating accumulation with a sticky sat_flag; otherwise adds wrap.
module nn_layer_sched #(
   parameter int N_IN  = 2,
   parameter int N_OUT = 3,
   parameter int W_W   = 8,
   parameter int ACC_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   nn_layer_sched_if.slave   bus
);
   localparam int N_CFG = N_OUT * (N_IN + 1);
   localparam int AW    = (N_CFG > 1) ? $clog2(N_CFG) : 1;
   localparam int NW    = (N_OUT > 1) ? $clog2(N_OUT) : 1;
   localparam int IW    = (N_IN > 1) ? $clog2(N_IN) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_MAC,
      S_BIAS,
      S_ACT,
      S_EMIT
   } state_t;

   state_t                  state_q, state_d;
   logic [NW-1:0]           n_q, n_d;
   logic [IW-1:0]           i_q, i_d;
   logic signed [ACC_W-1:0] acc_q, acc_d;
   logic [N_IN-1:0]         x_q, x_d;
   logic [N_OUT-1:0]        y_q, y_d;
   logic                    sat_q, sat_d;
   logic signed [W_W-1:0]   w_q [N_OUT][N_IN];
   logic signed [W_W-1:0]   w_d [N_OUT][N_IN];
   logic signed [W_W-1:0]   b_q [N_OUT];
   logic signed [W_W-1:0]   b_d [N_OUT];

   logic signed [W_W-1:0]   w_sel, b_sel;
   logic signed [ACC_W-1:0] w_ext, b_ext;
   logic                    x_sel;
   logic [ACC_W:0]          add_r;

   // Returns {overflow, sum}; overflow can only be set when saturation is built in.
   function automatic logic [ACC_W:0] acc_add(input logic signed [ACC_W-1:0] a,
                                              input logic signed [ACC_W-1:0] b);
`ifdef NN_SAT_EN
      logic signed [ACC_W:0] s;
      s = {a[ACC_W-1], a} + {b[ACC_W-1], b};
      if (s[ACC_W] != s[ACC_W-1]) begin
         if (s[ACC_W])
            return {1'b1, 1'b1, {(ACC_W-1){1'b0}}};
         else
            return {1'b1, 1'b0, {(ACC_W-1){1'b1}}};
      end
      return {1'b0, s[ACC_W-1:0]};
`else
      return {1'b0, a + b};
`endif
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         n_q     <= '0;
         i_q     <= '0;
         acc_q   <= '0;
         x_q     <= '0;
         y_q     <= '0;
         sat_q   <= 1'b0;
         w_q     <= '{default: '0};
         b_q     <= '{default: '0};
      end else begin
         state_q <= state_d;
         n_q     <= n_d;
         i_q     <= i_d;
         acc_q   <= acc_d;
         x_q     <= x_d;
         y_q     <= y_d;
         sat_q   <= sat_d;
         w_q     <= w_d;
         b_q     <= b_d;
      end
   end

   always_comb begin
      state_d = state_q;
      n_d     = n_q;
      i_d     = i_q;
      acc_d   = acc_q;
      x_d     = x_q;
      y_d     = y_q;
      sat_d   = sat_q;
      w_d     = w_q;
      b_d     = b_q;
      w_sel   = '0;
      b_sel   = '0;
      x_sel   = 1'b0;
      add_r   = '0;

      // Mux loops keep index widths exact for any N_IN/N_OUT.
      for (int n = 0; n < N_OUT; n++) begin
         if (n_q == NW'(n)) b_sel = b_q[n];
         for (int i = 0; i < N_IN; i++) begin
            if (n_q == NW'(n) && i_q == IW'(i)) w_sel = w_q[n][i];
         end
      end
      for (int i = 0; i < N_IN; i++) begin
         if (i_q == IW'(i)) x_sel = x_q[i];
      end
      w_ext = w_sel;
      b_ext = b_sel;

      // Config writes land only in IDLE, so the evaluation accepted on the same edge sees them.
      if (bus.cfg_we && state_q == S_IDLE) begin
         for (int n = 0; n < N_OUT; n++) begin
            for (int i = 0; i < N_IN; i++) begin
               if (bus.cfg_addr == AW'(n * (N_IN + 1) + i)) w_d[n][i] = bus.cfg_data;
            end
            if (bus.cfg_addr == AW'(n * (N_IN + 1) + N_IN)) b_d[n] = bus.cfg_data;
         end
      end

      unique case (state_q)
         S_IDLE: begin
            if (bus.in_valid) begin
               x_d     = bus.in_x;
               acc_d   = '0;
               n_d     = '0;
               i_d     = '0;
               sat_d   = 1'b0;
               state_d = S_MAC;
            end
         end
         S_MAC: begin
            if (x_sel) begin
               add_r = acc_add(acc_q, w_ext);
               acc_d = add_r[ACC_W-1:0];
               if (add_r[ACC_W]) sat_d = 1'b1;
            end
            if (i_q == IW'(N_IN - 1)) state_d = S_BIAS;
            else                      i_d     = i_q + IW'(1);
         end
         S_BIAS: begin
            add_r = acc_add(acc_q, b_ext);
            acc_d = add_r[ACC_W-1:0];
            if (add_r[ACC_W]) sat_d = 1'b1;
            state_d = S_ACT;
         end
         S_ACT: begin
            // Strictly positive fires; zero stays low.
            for (int n = 0; n < N_OUT; n++) begin
               if (n_q == NW'(n)) y_d[n] = !acc_q[ACC_W-1] && (acc_q != '0);
            end
            acc_d = '0;
            i_d   = '0;
            if (n_q == NW'(N_OUT - 1)) begin
               state_d = S_EMIT;
            end else begin
               n_d     = n_q + NW'(1);
               state_d = S_MAC;
            end
         end
         S_EMIT: begin
            if (bus.out_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign bus.in_ready  = (state_q == S_IDLE);
   assign bus.out_valid = (state_q == S_EMIT);
   assign bus.busy      = (state_q != S_IDLE);
   assign bus.out_y     = y_q;
   assign bus.sat_flag  = sat_q;
endmodule
